freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on SigIn (legal values 2..4).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the width of Din, Period, HighTime and all internal counters.
REQ-003 Clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 Enable  input  1  high = measurement running; low = idle and configurable.
REQ-006 Din  input  WIDTH  configuration data, the timeout limit in Clk cycles.
REQ-007 ConfigTimeout  input  1  load strobe for Din into the timeout limit register.
REQ-008 SigIn  input  1  asynchronous signal to measure, e.g. a divided clock.
REQ-009 Period  output  WIDTH  Clk cycles between the last two SigIn rising edges.
REQ-010 HighTime  output  WIDTH  Clk cycles SigIn was high within that period.
REQ-011 Valid  output  1  one-cycle pulse; Period and HighTime were updated this cycle.
REQ-012 Timeout  output  1  sticky flag; no rising edge arrived within the limit.
REQ-013 Busy  output  1  high while in ARM or MEASURE.

Function
REQ-014 SigIn SHALL pass through SYNC_STAGES flops and then one edge-detect flop; a rising edge is the synced value going 1 while the edge-detect flop holds 0.
REQ-015 Latency: with SYNC_STAGES=2, a SigIn rise first sampled at Clk edge k SHALL produce Valid high in the cycle after edge k+2.
REQ-016 The state machine SHALL have the states IDLE, ARM and MEASURE.
REQ-017 IDLE transitions: go to ARM when Enable=1; otherwise stay in IDLE.
REQ-018 ARM transitions: on the first rising edge, clear PerCnt to 1 and HiCnt to 1, go to MEASURE, and assert no Valid (partial period).
REQ-019 MEASURE, each cycle with no edge: PerCnt increments by 1; HiCnt increments by 1 when the synced SigIn is 1.
REQ-020 MEASURE, on a rising edge: Period<=PerCnt; HighTime<=HiCnt; Valid=1; Timeout<=0; PerCnt<=1; HiCnt<=1; state stays MEASURE.
REQ-021 A square SigIn of N Clk cycles with H high cycles SHALL yield Period=N and HighTime=H.
REQ-022 PerCnt and HiCnt SHALL saturate at 2^WIDTH-1 and never wrap.
REQ-023 Timeout limit register TLim resets to all-ones.
REQ-024 TLim loads Din on a cycle with ConfigTimeout=1 and Enable=0.
REQ-025 ConfigTimeout SHALL be ignored while Enable=1.
REQ-026 In MEASURE, when PerCnt equals TLim with no edge in that cycle: Timeout<=1, return to ARM, no Valid; Period and HighTime hold.
REQ-027 TLim=0 SHALL disable timeout detection.
REQ-028 Enable falling SHALL take any state to IDLE on the next edge and abandon the partial measurement.
REQ-029 In IDLE: Valid=0; Period, HighTime and Timeout hold.
REQ-030 A rising edge and Enable falling in the same cycle: Enable wins and no Valid is produced.
REQ-031 The synchronizer and edge-detect flops SHALL keep running in IDLE, so no false edge occurs on re-enable while SigIn is high.
REQ-032 Busy=1 exactly in ARM and MEASURE.

Reset
REQ-033 On Reset=1: state=IDLE; Period=0; HighTime=0; Valid=0; Timeout=0; Busy=0; PerCnt=0; HiCnt=0; TLim=all-ones; synchronizer and edge-detect flops=0.
REQ-034 Reset SHALL override Enable and ConfigTimeout in the same cycle.
REQ-035 Reset asserted mid-measurement SHALL discard the partial measurement without a Valid pulse.

Verification
REQ-036 Reset for 3 cycles, Enable=1, SigIn toggling every 5 Clk cycles -> first Valid after the second rising edge, then every 10 cycles, with Period=10 and HighTime=5.
REQ-037 SigIn at 3 cycles high / 7 cycles low -> Period=10, HighTime=3; then change to 2 high / 2 low -> next Valid reports Period=4, HighTime=2.
REQ-038 Enable=0, ConfigTimeout=1, Din=20, then Enable=1, one SigIn edge, then SigIn held low -> Timeout=1 20 cycles after the edge, Busy stays 1, no Valid; next two edges -> Valid with Timeout cleared.
REQ-039 ConfigTimeout=1 with Din=7 while Enable=1 -> TLim unchanged, verified by no timeout at 7 cycles.
REQ-040 Enable dropped mid-period, or Reset pulsed mid-period -> no Valid; outputs hold (Enable case) or clear to 0 (Reset case); re-enable with SigIn high -> no spurious edge, and the first Valid comes after two genuine rising edges.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: measures the period and high time of an asynchronous input
// in system-clock cycles. SigIn is synchronized, rising edges are detected,
// and a three-state controller (IDLE / ARM / MEASURE) counts clocks between
// successive edges. A programmable limit flags a missing edge (Timeout).
module freq_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Din,
  input  logic             ConfigTimeout,
  input  logic             SigIn,
  output logic [WIDTH-1:0] Period,
  output logic [WIDTH-1:0] HighTime,
  output logic             Valid,
  output logic             Timeout,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   edge_ff;
  logic                   synced;
  logic                   rise;
  logic [WIDTH-1:0]       per_cnt;
  logic [WIDTH-1:0]       hi_cnt;
  logic [WIDTH-1:0]       tlim;

  // Counters stop at all-ones instead of wrapping to zero.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == ONES) return v;
    return v + ONE;
  endfunction

  // Synchronizer chain and edge-detect flop; these run in every state so a
  // signal already high at re-enable is never seen as a fresh edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_ff <= '0;
      edge_ff <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], SigIn};
      edge_ff <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign synced = sync_ff[SYNC_STAGES-1];
  assign rise   = synced & ~edge_ff;

  // Timeout limit register; only writable while the meter is idle-configurable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tlim <= ONES;
    end else if (ConfigTimeout && !Enable) begin
      tlim <= Din;
    end
  end

  // Measurement controller: counts, publishes results and raises timeout.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      Period   <= '0;
      HighTime <= '0;
      Valid    <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable) state <= ARM;
        end
        ARM: begin
          // The first edge only opens a period; nothing is reported yet.
          if (!Enable) begin
            state <= IDLE;
          end else if (rise) begin
            per_cnt <= ONE;
            hi_cnt  <= ONE;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (!Enable) begin
            // Disable beats a coincident edge; the partial period is dropped.
            state <= IDLE;
          end else if (rise) begin
            Period   <= per_cnt;
            HighTime <= hi_cnt;
            Valid    <= 1'b1;
            Timeout  <= 1'b0;
            per_cnt  <= ONE;
            hi_cnt   <= ONE;
          end else if ((tlim != '0) && (per_cnt == tlim)) begin
            Timeout <= 1'b1;
            state   <= ARM;
          end else begin
            per_cnt <= sat_inc(per_cnt);
            if (synced) hi_cnt <= sat_inc(hi_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy follows the registered state directly.
  always_comb begin
    Busy = (state == ARM) || (state == MEASURE);
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: expected Period/HighTime pairs are queued as SigIn
// waveforms are driven and popped when the DUT pulses Valid.
module tb_freq_meter;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Enable;
  logic [W-1:0] Din;
  logic         ConfigTimeout;
  logic         SigIn;
  logic [W-1:0] Period;
  logic [W-1:0] HighTime;
  logic         Valid;
  logic         Timeout;
  logic         Busy;

  typedef struct packed {
    logic [W-1:0] per;
    logic [W-1:0] hi;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Waveform bookkeeping: the period most recently driven, if any.
  bit   have_prev = 0;
  int   prev_n = 0;
  int   prev_h = 0;

  freq_meter #(.SYNC_STAGES(2), .WIDTH(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Enable(Enable),
    .Din(Din),
    .ConfigTimeout(ConfigTimeout),
    .SigIn(SigIn),
    .Period(Period),
    .HighTime(HighTime),
    .Valid(Valid),
    .Timeout(Timeout),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Scoreboard: every Valid must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got Period=%0d HighTime=%0d, required no Valid", Period, HighTime);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (Period !== e.per || HighTime !== e.hi) begin
          fails++;
          $display("FAIL valid_data: got Period=%0d HighTime=%0d, required Period=%0d HighTime=%0d",
                   Period, HighTime, e.per, e.hi);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Drive cnt periods of h high / l low cycles, queueing a result on every
  // rising edge that closes a complete period.
  task automatic square(input int h, input int l, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (have_prev) exp_q.push_back({32'(prev_n), 32'(prev_h)});
      SigIn = 1'b1;
      step(h);
      SigIn = 1'b0;
      step(l);
      have_prev = 1;
      prev_n = h + l;
      prev_h = h;
    end
  endtask

  task automatic end_test(input string name);
    SigIn = 1'b0;
    Enable = 1'b0;
    have_prev = 0;
    step(4);
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL %s_pending: got %0d outstanding results, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    // Reset must override Enable and a config write with a small limit.
    Reset = 1'b1;
    Enable = 1'b1;
    ConfigTimeout = 1'b1;
    Din = 32'd3;
    SigIn = 1'b0;
    step(3);
    @(negedge Clk);
    tests++; if (Period !== 0)   begin fails++; $display("FAIL reset_period: got %0d, required 0", Period); end
    tests++; if (HighTime !== 0) begin fails++; $display("FAIL reset_hightime: got %0d, required 0", HighTime); end
    tests++; if (Valid !== 0)    begin fails++; $display("FAIL reset_valid: got %0b, required 0", Valid); end
    tests++; if (Timeout !== 0)  begin fails++; $display("FAIL reset_timeout: got %0b, required 0", Timeout); end
    tests++; if (Busy !== 0)     begin fails++; $display("FAIL reset_busy: got %0b, required 0", Busy); end
    Reset = 1'b0;
    Enable = 1'b0;
    ConfigTimeout = 1'b0;
    Din = '0;
    step(2);
  endtask

  task automatic test_latency;
    Enable = 1'b1;
    step(2);
    @(negedge Clk);
    tests++; if (Busy !== 1) begin fails++; $display("FAIL latency_busy: got %0b, required 1", Busy); end
    SigIn = 1'b1; step(4);
    SigIn = 1'b0; step(4);
    exp_q.push_back({32'd8, 32'd4});
    SigIn = 1'b1;
    step(2);
    @(negedge Clk);
    tests++; if (Valid !== 0) begin fails++; $display("FAIL latency_early: got Valid=%0b, required 0", Valid); end
    step(1);
    @(negedge Clk);
    tests++; if (Valid !== 1) begin fails++; $display("FAIL latency_ontime: got Valid=%0b, required 1", Valid); end
    step(1);
    end_test("latency");
  endtask

  task automatic test_basic;
    Enable = 1'b1;
    step(2);
    square(5, 5, 6);
    @(negedge Clk);
    tests++; if (Timeout !== 0) begin fails++; $display("FAIL basic_timeout: got %0b, required 0", Timeout); end
    end_test("basic");
  endtask

  task automatic test_duty;
    Enable = 1'b1;
    step(2);
    square(3, 7, 4);
    square(2, 2, 4);
    end_test("duty");
  endtask

  task automatic test_timeout;
    ConfigTimeout = 1'b1;
    Din = 32'd20;
    step(1);
    ConfigTimeout = 1'b0;
    Enable = 1'b1;
    step(2);
    SigIn = 1'b1; step(3);
    SigIn = 1'b0; step(19);
    @(negedge Clk);
    tests++; if (Timeout !== 0) begin fails++; $display("FAIL timeout_early: got %0b, required 0", Timeout); end
    step(1);
    @(negedge Clk);
    tests++; if (Timeout !== 1) begin fails++; $display("FAIL timeout_set: got %0b, required 1", Timeout); end
    tests++; if (Busy !== 1)    begin fails++; $display("FAIL timeout_busy: got %0b, required 1", Busy); end
    step(5);
    @(negedge Clk);
    tests++; if (Timeout !== 1) begin fails++; $display("FAIL timeout_sticky: got %0b, required 1", Timeout); end
    have_prev = 0;
    square(5, 5, 2);
    @(negedge Clk);
    tests++; if (Timeout !== 0) begin fails++; $display("FAIL timeout_clear: got %0b, required 0", Timeout); end
    end_test("timeout");
  endtask

  task automatic test_cfg_ignored;
    Enable = 1'b1;
    step(2);
    ConfigTimeout = 1'b1;
    Din = 32'd7;
    step(1);
    ConfigTimeout = 1'b0;
    SigIn = 1'b1; step(2);
    SigIn = 1'b0; step(12);
    @(negedge Clk);
    tests++; if (Timeout !== 0) begin fails++; $display("FAIL cfg_ignored: got Timeout=%0b, required 0", Timeout); end
    end_test("cfg_ignored");
  endtask

  task automatic test_tlim_zero;
    ConfigTimeout = 1'b1;
    Din = 32'd0;
    step(1);
    ConfigTimeout = 1'b0;
    Enable = 1'b1;
    step(2);
    SigIn = 1'b1; step(3);
    SigIn = 1'b0; step(40);
    @(negedge Clk);
    tests++; if (Timeout !== 0) begin fails++; $display("FAIL tlim_zero_timeout: got %0b, required 0", Timeout); end
    tests++; if (Busy !== 1)    begin fails++; $display("FAIL tlim_zero_busy: got %0b, required 1", Busy); end
    end_test("tlim_zero");
  endtask

  task automatic test_disable;
    Enable = 1'b1;
    step(2);
    square(4, 4, 3);
    // This edge would close a period, but Enable drops in its detect cycle.
    SigIn = 1'b1;
    step(2);
    Enable = 1'b0;
    step(6);
    @(negedge Clk);
    tests++; if (Period !== 8)   begin fails++; $display("FAIL disable_period_hold: got %0d, required 8", Period); end
    tests++; if (HighTime !== 4) begin fails++; $display("FAIL disable_hightime_hold: got %0d, required 4", HighTime); end
    tests++; if (Busy !== 0)     begin fails++; $display("FAIL disable_busy: got %0b, required 0", Busy); end
    // Re-enable while SigIn is still high: no edge may be seen.
    have_prev = 0;
    Enable = 1'b1;
    step(3);
    SigIn = 1'b0;
    step(4);
    square(4, 4, 3);
    end_test("disable");
  endtask

  task automatic test_reset_mid;
    Enable = 1'b1;
    step(2);
    square(6, 4, 2);
    exp_q.push_back({32'(prev_n), 32'(prev_h)});
    SigIn = 1'b1;
    step(5);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    @(negedge Clk);
    tests++; if (Period !== 0)   begin fails++; $display("FAIL resetmid_period: got %0d, required 0", Period); end
    tests++; if (HighTime !== 0) begin fails++; $display("FAIL resetmid_hightime: got %0d, required 0", HighTime); end
    tests++; if (Busy !== 0)     begin fails++; $display("FAIL resetmid_busy: got %0b, required 0", Busy); end
    SigIn = 1'b0;
    step(3);
    end_test("reset_mid");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_duty();
    test_timeout();
    test_cfg_ignored();
    test_tlim_zero();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
